// File: rtl/qspi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// qspi_mem_arbiter
// Shares one QSPI transaction engine between the instruction-fetch port (ibus)
// and the data port (dbus). One word transaction at a time.
// - The top address bit picks the device: 0 = flash, 1 = PSRAM.
// - Data normally wins arbitration. A fetch is forced through after STREAK_MAX
//   consecutive data grants that it had to wait behind.
// - Data writes to flash are rejected without touching the engine.
// - A transaction the engine never completes is aborted after TIMEOUT_CYC cycles.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   ibus_req_i/addr_i                fetch request (held until ack)
//   ibus_ack_o/err_o/rdata_o         fetch response (ack is a 1-cycle pulse)
//   dbus_req_i/we_i/be_i/addr_i/wdata_i  data request (held until ack)
//   dbus_ack_o/err_o/rdata_o         data response (ack is a 1-cycle pulse)
//   mem_req_o/we_o/be_o/sel_o/addr_o/wdata_o  engine request, stable while held
//   mem_done_i/rdata_i               engine completion and read data
//   mem_abort_o                      1-cycle pulse, engine must go back to idle
//   busy_o                           arbiter is not idle
// -----------------------------------------------------------------------------
module qspi_mem_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int TIMEOUT_CYC = 1024,
    parameter int STREAK_MAX  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ibus_req_i,
    input  logic [ADDR_W-1:0] ibus_addr_i,
    output logic              ibus_ack_o,
    output logic              ibus_err_o,
    output logic [31:0]       ibus_rdata_o,
    input  logic              dbus_req_i,
    input  logic              dbus_we_i,
    input  logic [3:0]        dbus_be_i,
    input  logic [ADDR_W-1:0] dbus_addr_i,
    input  logic [31:0]       dbus_wdata_i,
    output logic              dbus_ack_o,
    output logic              dbus_err_o,
    output logic [31:0]       dbus_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic              mem_sel_o,
    output logic [23:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_done_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              mem_abort_o,
    output logic              busy_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int STK_W = $clog2(STREAK_MAX + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(STREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [STK_W-1:0] streak_r;
    logic [STK_W-1:0] streak_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             owner_data_r;
    logic             grant_fetch_s;
    logic             grant_data_s;
    logic             flash_wr_s;
    logic             done_s;
    logic             tmo_s;
    logic             fetch_starved_s;

    logic             ibus_ack_r;
    logic             ibus_err_r;
    logic [31:0]      ibus_rdata_r;
    logic             dbus_ack_r;
    logic             dbus_err_r;
    logic [31:0]      dbus_rdata_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [3:0]       mem_be_r;
    logic             mem_sel_r;
    logic [23:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic             mem_abort_r;
    logic             busy_r;

    assign ibus_ack_o   = ibus_ack_r;
    assign ibus_err_o   = ibus_err_r;
    assign ibus_rdata_o = ibus_rdata_r;
    assign dbus_ack_o   = dbus_ack_r;
    assign dbus_err_o   = dbus_err_r;
    assign dbus_rdata_o = dbus_rdata_r;
    assign mem_req_o    = mem_req_r;
    assign mem_we_o     = mem_we_r;
    assign mem_be_o     = mem_be_r;
    assign mem_sel_o    = mem_sel_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_wdata_o  = mem_wdata_r;
    assign mem_abort_o  = mem_abort_r;
    assign busy_o       = busy_r;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout in BUSY
    always_comb begin
        state_nxt_s     = state_r;
        grant_fetch_s   = 1'b0;
        grant_data_s    = 1'b0;
        flash_wr_s      = 1'b0;
        done_s          = 1'b0;
        tmo_s           = 1'b0;
        fetch_starved_s = ibus_req_i && (streak_r == STK_LIMIT);
        case (state_r)
            ST_IDLE: begin
                if (dbus_req_i && !fetch_starved_s) begin
                    grant_data_s = 1'b1;
                    if (dbus_we_i && !dbus_addr_i[ADDR_W-1]) begin
                        flash_wr_s  = 1'b1;
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else if (ibus_req_i) begin
                    grant_fetch_s = 1'b1;
                    state_nxt_s   = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A done on the final allowed cycle still counts as completion.
                if (mem_done_i) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Fairness streak: data grants that overtook a waiting fetch
    always_comb begin
        streak_nxt_s = streak_r;
        if (!ibus_req_i || grant_fetch_s) begin
            streak_nxt_s = {STK_W{1'b0}};
        end else if (grant_data_s && (streak_r != STK_LIMIT)) begin
            streak_nxt_s = streak_r + STK_W'(1);
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Streak counter and busy flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_r <= {STK_W{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            streak_r <= streak_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    // Engine request fields, timeout counter and registered responses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ibus_ack_r   <= 1'b0;
            ibus_err_r   <= 1'b0;
            ibus_rdata_r <= 32'h0000_0000;
            dbus_ack_r   <= 1'b0;
            dbus_err_r   <= 1'b0;
            dbus_rdata_r <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'h0;
            mem_sel_r    <= 1'b0;
            mem_addr_r   <= 24'h00_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_abort_r  <= 1'b0;
            owner_data_r <= 1'b0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
        end else begin
            ibus_ack_r  <= 1'b0;
            dbus_ack_r  <= 1'b0;
            mem_abort_r <= 1'b0;
            if (grant_fetch_s) begin
                mem_req_r    <= 1'b1;
                mem_we_r     <= 1'b0;
                mem_be_r     <= 4'hF;
                mem_sel_r    <= ibus_addr_i[ADDR_W-1];
                mem_addr_r   <= ibus_addr_i[23:0];
                mem_wdata_r  <= 32'h0000_0000;
                owner_data_r <= 1'b0;
                tmo_cnt_r    <= {TMO_W{1'b0}};
            end else if (grant_data_s && flash_wr_s) begin
                // Flash is read-only: answer immediately, engine untouched.
                dbus_ack_r   <= 1'b1;
                dbus_err_r   <= 1'b1;
                dbus_rdata_r <= 32'h0000_0000;
            end else if (grant_data_s) begin
                mem_req_r    <= 1'b1;
                mem_we_r     <= dbus_we_i;
                mem_be_r     <= dbus_be_i;
                mem_sel_r    <= dbus_addr_i[ADDR_W-1];
                mem_addr_r   <= dbus_addr_i[23:0];
                mem_wdata_r  <= dbus_wdata_i;
                owner_data_r <= 1'b1;
                tmo_cnt_r    <= {TMO_W{1'b0}};
            end else if (done_s || tmo_s) begin
                mem_req_r   <= 1'b0;
                mem_abort_r <= tmo_s;
                if (owner_data_r) begin
                    dbus_ack_r   <= 1'b1;
                    dbus_err_r   <= tmo_s;
                    dbus_rdata_r <= (tmo_s || mem_we_r) ? 32'h0000_0000 : mem_rdata_i;
                end else begin
                    ibus_ack_r   <= 1'b1;
                    ibus_err_r   <= tmo_s;
                    ibus_rdata_r <= tmo_s ? 32'h0000_0000 : mem_rdata_i;
                end
            end else if (state_r == ST_BUSY) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qspi_mem_arbiter
// Scoreboarded bench: requester tasks push the expected response when they
// issue a request; a monitor pops and compares on every ack. A small engine
// model answers mem_req_o with a random or fixed delay (or never), and returns
// a fixed function of the device address as memory contents.
// -----------------------------------------------------------------------------
module tb_qspi_mem_arbiter;

    localparam int TMO    = 16;
    localparam int STREAK = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ibus_req_i;
    logic [24:0] ibus_addr_i;
    logic        ibus_ack_o;
    logic        ibus_err_o;
    logic [31:0] ibus_rdata_o;
    logic        dbus_req_i;
    logic        dbus_we_i;
    logic [3:0]  dbus_be_i;
    logic [24:0] dbus_addr_i;
    logic [31:0] dbus_wdata_i;
    logic        dbus_ack_o;
    logic        dbus_err_o;
    logic [31:0] dbus_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_sel_o;
    logic [23:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic        mem_abort_o;
    logic        busy_o;

    qspi_mem_arbiter #(.ADDR_W(25), .TIMEOUT_CYC(TMO), .STREAK_MAX(STREAK)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ibus_req_i(ibus_req_i), .ibus_addr_i(ibus_addr_i), .ibus_ack_o(ibus_ack_o),
        .ibus_err_o(ibus_err_o), .ibus_rdata_o(ibus_rdata_o),
        .dbus_req_i(dbus_req_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i),
        .dbus_addr_i(dbus_addr_i), .dbus_wdata_i(dbus_wdata_i), .dbus_ack_o(dbus_ack_o),
        .dbus_err_o(dbus_err_o), .dbus_rdata_o(dbus_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i), .mem_abort_o(mem_abort_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          kind;   // 0 engine completion, 1 timeout, 2 flash-write reject
    } resp_t;

    resp_t exp_i[$];
    resp_t exp_d[$];
    bit    grant_log[$];     // 0 = fetch acked, 1 = data acked

    int n_cmp = 0;
    int n_bad = 0;

    // Engine behaviour: 0 random delay, 1 silent, 2 fixed delay and data
    int          eng_mode = 0;
    int          eng_fix_dly = 0;
    logic [31:0] eng_fix_data = 32'h0;
    int          last_done_cyc = -10;
    int          mem_starts = 0;

    // Currently outstanding requests, as the requesters see them
    bit          i_pend = 1'b0;
    logic [24:0] i_addr = 25'h0;
    bit          d_pend = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [24:0] d_addr = 25'h0;
    logic [31:0] d_wdata = 32'h0;

    function automatic logic [31:0] mem_word(input logic [24:0] a);
        return ({7'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic score(input bit port);
        resp_t       r;
        string       pfx;
        logic        err;
        logic [31:0] rd;
        if (port) begin
            pfx = "dbus"; err = dbus_err_o; rd = dbus_rdata_o;
        end else begin
            pfx = "ibus"; err = ibus_err_o; rd = ibus_rdata_o;
        end
        grant_log.push_back(port);
        if ((port ? exp_d.size() : exp_i.size()) == 0) begin
            check({pfx, "_ack_without_request"}, 0, 1);
        end else begin
            if (port) r = exp_d.pop_front();
            else      r = exp_i.pop_front();
            check({pfx, "_err"}, err, r.err);
            check({pfx, "_rdata"}, rd, r.rdata);
            if (r.kind == 0)      check("ack_one_cycle_after_done", cyc, last_done_cyc + 1);
            else if (r.kind == 1) check("abort_with_timeout_ack", mem_abort_o, 1);
            else                  check("no_abort_on_flash_reject", mem_abort_o, 0);
        end
    endtask

    // Monitor: compares every ack against the scoreboard
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (ibus_ack_o || dbus_ack_o) check("single_ack", ibus_ack_o & dbus_ack_o, 0);
                if (ibus_ack_o) score(1'b0);
                if (dbus_ack_o) score(1'b1);
                if (mem_abort_o) check("abort_only_when_engine_silent", eng_mode, 1);
            end
        end
    end

    // Engine model: answers requests, checks request fields, plants stray dones
    initial begin : engine
        bit          in_txn;
        int          wcnt;
        int          dly;
        logic [61:0] snap;
        logic        ok_i;
        logic        ok_d;
        in_txn = 1'b0; wcnt = 0; dly = 0; snap = '0;
        mem_done_i = 1'b0; mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            mem_done_i  = 1'b0;
            mem_rdata_i = $urandom;
            if (rst_i || !mem_req_o) begin
                if (in_txn && mem_abort_o) check("abort_after_busy_cycles", wcnt, TMO);
                in_txn = 1'b0;
                // done outside a transaction must be ignored
                if (!rst_i && ($urandom_range(0, 3) == 0)) mem_done_i = 1'b1;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wcnt = 0;
                    mem_starts++;
                    snap = {mem_we_o, mem_be_o, mem_sel_o, mem_addr_o, mem_wdata_o};
                    ok_i = i_pend && !mem_we_o && (mem_be_o == 4'hF) &&
                           ({mem_sel_o, mem_addr_o} == i_addr);
                    ok_d = d_pend && !(d_we && !d_addr[24]) && (mem_we_o == d_we) &&
                           (mem_be_o == d_be) && ({mem_sel_o, mem_addr_o} == d_addr) &&
                           (!d_we || (mem_wdata_o == d_wdata));
                    check("mem_fields_match_request", ok_i || ok_d, 1);
                    check("busy_while_busy", busy_o, 1);
                    dly = (eng_mode == 2) ? eng_fix_dly : $urandom_range(0, 8);
                end else begin
                    check("mem_fields_stable", {mem_we_o, mem_be_o, mem_sel_o, mem_addr_o, mem_wdata_o}, snap);
                end
                if (eng_mode != 1 && wcnt == dly) begin
                    mem_done_i  = 1'b1;
                    mem_rdata_i = (eng_mode == 2) ? eng_fix_data : mem_word({mem_sel_o, mem_addr_o});
                    last_done_cyc = cyc;
                end
                wcnt++;
            end
        end
    end

    task automatic do_fetch(input logic [24:0] a, output int lat);
        resp_t r;
        r.kind  = (eng_mode == 1) ? 1 : 0;
        r.err   = (eng_mode == 1);
        r.rdata = (eng_mode == 1) ? 32'h0 : ((eng_mode == 2) ? eng_fix_data : mem_word(a));
        exp_i.push_back(r);
        i_addr = a; i_pend = 1'b1;
        ibus_addr_i = a; ibus_req_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!ibus_ack_o && lat < 300);
        check("ibus_ack_within_bound", ibus_ack_o, 1);
        ibus_req_i = 1'b0; i_pend = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [24:0] a,
                           input logic [31:0] wd, output int lat);
        resp_t r;
        if (we && !a[24]) begin
            r.kind = 2; r.err = 1'b1; r.rdata = 32'h0;
        end else if (eng_mode == 1) begin
            r.kind = 1; r.err = 1'b1; r.rdata = 32'h0;
        end else begin
            r.kind = 0; r.err = 1'b0;
            r.rdata = we ? 32'h0 : ((eng_mode == 2) ? eng_fix_data : mem_word(a));
        end
        exp_d.push_back(r);
        d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_pend = 1'b1;
        dbus_we_i = we; dbus_be_i = be; dbus_addr_i = a; dbus_wdata_i = wd; dbus_req_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!dbus_ack_o && lat < 300);
        check("dbus_ack_within_bound", dbus_ack_o, 1);
        dbus_req_i = 1'b0; d_pend = 1'b0;
    endtask

    task automatic fetch_loop(input int n, input int gmax);
        int lat;
        for (int i = 0; i < n; i++) begin
            do_fetch({$urandom_range(0, 1) == 1, 22'($urandom), 2'b00}, lat);
            repeat ($urandom_range(0, gmax)) @(negedge clk_i);
        end
    endtask

    task automatic data_loop(input int n, input int gmax);
        int lat;
        for (int i = 0; i < n; i++) begin
            do_data($urandom_range(0, 1) == 1, 4'($urandom), 25'($urandom), $urandom, lat);
            repeat ($urandom_range(0, gmax)) @(negedge clk_i);
        end
    endtask

    // Hard stop in case something never returns
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        int starts_before;
        rst_i = 1'b1;
        ibus_req_i = 1'b0; ibus_addr_i = 25'h0;
        dbus_req_i = 1'b0; dbus_we_i = 1'b0; dbus_be_i = 4'h0;
        dbus_addr_i = 25'h0; dbus_wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check("rst_ibus_ack", ibus_ack_o, 0);
        check("rst_dbus_ack", dbus_ack_o, 0);
        check("rst_errs", {ibus_err_o, dbus_err_o}, 0);
        check("rst_rdata", {ibus_rdata_o, dbus_rdata_o}, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_abort", mem_abort_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_mem_fields", {mem_we_o, mem_be_o, mem_sel_o, mem_addr_o, mem_wdata_o}, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Fetch completing exactly on the last allowed cycle
        eng_mode = 2; eng_fix_dly = TMO - 1; eng_fix_data = 32'hDEAD_BEEF;
        do_fetch(25'h000_0100, lat);
        check("fetch_limit_latency", lat, TMO + 1);
        repeat (2) @(negedge clk_i);

        // PSRAM partial write
        eng_mode = 0;
        do_data(1'b1, 4'b0011, 25'h100_0040, 32'h1234_ABCD, lat);
        repeat (2) @(negedge clk_i);

        // Flash write rejected without engine activity
        starts_before = mem_starts;
        do_data(1'b1, 4'hF, 25'h000_0040, 32'hCAFE_F00D, lat);
        check("flash_write_ack_latency", lat, 1);
        repeat (3) @(negedge clk_i);
        check("flash_write_no_mem_req", mem_starts, starts_before);

        // Silent engine: fetch and data read both time out
        eng_mode = 1;
        do_fetch(25'h100_0200, lat);
        check("timeout_fetch_latency", lat, TMO + 1);
        repeat (2) @(negedge clk_i);
        do_data(1'b0, 4'hF, 25'h000_0300, 32'h0, lat);
        repeat (2) @(negedge clk_i);

        // Both ports held continuously: D,D,D,D,I repeating
        eng_mode = 0;
        grant_log.delete();
        fork
            fetch_loop(6, 0);
            data_loop(24, 0);
        join
        check("fairness_grant_count", grant_log.size(), 30);
        for (int k = 1; k <= 30 && k <= grant_log.size(); k++)
            check("fairness_grant_order", grant_log[k-1], (k % (STREAK + 1) == 0) ? 0 : 1);
        repeat (3) @(negedge clk_i);

        // Random traffic on both ports
        fork
            fetch_loop(40, 3);
            data_loop(40, 3);
        join
        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", exp_i.size() + exp_d.size(), 0);

        // Reset while BUSY: request drops at once, no ack, no abort
        eng_mode = 1;
        i_addr = 25'h000_0400; i_pend = 1'b1;
        ibus_addr_i = 25'h000_0400; ibus_req_i = 1'b1;
        lat = 0;
        while (!mem_req_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check("reset_test_mem_req_seen", mem_req_o, 1);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("async_reset_drops_mem_req", mem_req_o, 0);
        check("async_reset_clears_busy", busy_o, 0);
        check("async_reset_no_abort", mem_abort_o, 0);
        ibus_req_i = 1'b0; i_pend = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_no_ibus_ack", ibus_ack_o, 0);
        rst_i = 1'b0;
        eng_mode = 0;
        repeat (2) @(negedge clk_i);
        do_fetch(25'h000_0800, lat);
        repeat (4) @(negedge clk_i);
        check("final_scoreboard_drained", exp_i.size() + exp_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
